// File: rtl/screen_seq_pkg.sv
// Shared definitions for the screen sequencer: screen geometry, pixel field
// widths, the sequencer state codes and a pixel bundle.
// Ports: none (package).
package screen_seq_pkg;

  localparam int SCR_W    = 160;
  localparam int SCR_H    = 120;
  localparam int COLOUR_W = 3;
  localparam int X_W      = $clog2(SCR_W);  // 8
  localparam int Y_W      = $clog2(SCR_H);  // 7
  localparam int STATE_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    S_DRAW_START = 3'd0,
    S_WAIT_START = 3'd1,
    S_DRAW_GAME  = 3'd2,
    S_PLAY       = 3'd3,
    S_DRAW_OVER  = 3'd4,
    S_WAIT_OVER  = 3'd5
  } state_t;

  typedef struct packed {
    logic [COLOUR_W-1:0] colour;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
  } pixel_t;

  function automatic logic is_draw_state(input state_t s);
    return (s == S_DRAW_START) || (s == S_DRAW_GAME) || (s == S_DRAW_OVER);
  endfunction

endpackage

// File: rtl/key_press_detect.sv
// Two-flop synchroniser for the active-low start pushbutton followed by a
// falling-edge detector that yields a single-cycle press pulse per key press.
// Ports: clk, reset (sync, active-low), start_n_i (raw button), press_o (pulse).
module key_press_detect (
  input  logic clk,
  input  logic reset,
  input  logic start_n_i,
  output logic press_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // All flops reset to the released level so reset release never looks like a press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= start_n_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // 1->0 on the synchronised level; holding the key low gives only one pulse.
  assign press_o = prev_q & ~sync_q;

endmodule

// File: rtl/screen_sequencer.sv
// Screen sequencer: steps start screen -> game -> game-over screen, enables the
// matching drawer and muxes its pixel stream onto a registered VGA port.
// Ports: clk, reset (sync, active-low), start_n, game_over, done_*, src0..2 pixels,
//        src1_plot -> draw_*, vga_colour/x/y/plot, state, timeout_err.
// Optional draw-state watchdog: define SCREEN_SEQ_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module screen_sequencer
  import screen_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_n,
  input  logic                game_over,
  input  logic                done_start,
  input  logic                done_game,
  input  logic                done_over,
  input  logic [COLOUR_W-1:0] src0_colour,
  input  logic [X_W-1:0]      src0_x,
  input  logic [Y_W-1:0]      src0_y,
  input  logic [COLOUR_W-1:0] src1_colour,
  input  logic [X_W-1:0]      src1_x,
  input  logic [Y_W-1:0]      src1_y,
  input  logic [COLOUR_W-1:0] src2_colour,
  input  logic [X_W-1:0]      src2_x,
  input  logic [Y_W-1:0]      src2_y,
  input  logic                src1_plot,
  output logic                draw_start,
  output logic                draw_game,
  output logic                draw_over,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic                vga_plot,
  output logic [STATE_W-1:0]  state,
  output logic                timeout_err
);

  state_t state_q, state_d;
  logic   press;
  logic   done_sel;
  logic   expired;

  pixel_t pix_q, pix_d;
  logic   plot_q, plot_d, plot_sel;
  logic   draw_start_q, draw_game_q, draw_over_q;

  key_press_detect u_key (
    .clk       (clk),
    .reset     (reset),
    .start_n_i (start_n),
    .press_o   (press)
  );

  // Only the done flag of the drawer owned by the current state counts.
  always_comb begin
    done_sel = 1'b0;
    case (state_q)
      S_DRAW_START: done_sel = done_start;
      S_DRAW_GAME:  done_sel = done_game;
      S_DRAW_OVER:  done_sel = done_over;
      default:      done_sel = 1'b0;
    endcase
  end

`ifdef SCREEN_SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;

  // cnt_q counts cycles already spent in the current draw state (0 on entry).
  assign expired = is_draw_state(state_q) && (cnt_q == CNT_LAST) && !done_sel;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if ((state_d != state_q) || !is_draw_state(state_q)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_q | expired;
    end
  end

  assign timeout_err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign expired            = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DRAW_START: if (done_sel || expired) state_d = S_WAIT_START;
      S_WAIT_START: if (press)               state_d = S_DRAW_GAME;
      S_DRAW_GAME:  if (done_sel || expired) state_d = S_PLAY;
      S_PLAY:       if (game_over)           state_d = S_DRAW_OVER;
      S_DRAW_OVER:  if (done_sel || expired) state_d = S_WAIT_OVER;
      S_WAIT_OVER:  if (press)               state_d = S_DRAW_START;
      default:                               state_d = S_DRAW_START;
    endcase
  end

  // Pixel source follows the state the pixel was produced in; waiting states hold.
  always_comb begin
    pix_d    = pix_q;
    plot_sel = 1'b0;
    case (state_q)
      S_DRAW_START: begin
        pix_d    = {src0_colour, src0_x, src0_y};
        plot_sel = 1'b1;
      end
      S_DRAW_GAME: begin
        pix_d    = {src1_colour, src1_x, src1_y};
        plot_sel = 1'b1;
      end
      S_DRAW_OVER: begin
        pix_d    = {src2_colour, src2_x, src2_y};
        plot_sel = 1'b1;
      end
      S_PLAY: begin
        pix_d    = {src1_colour, src1_x, src1_y};
        plot_sel = src1_plot;
      end
      default: ;
    endcase
  end

  // A pixel sampled on the cycle the state moves belongs to the outgoing
  // drawer, so it is never plotted in the first cycle of the new state.
  assign plot_d = plot_sel && (state_d == state_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_DRAW_START;
      draw_start_q <= 1'b0;
      draw_game_q  <= 1'b0;
      draw_over_q  <= 1'b0;
      pix_q        <= '0;
      plot_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      draw_start_q <= (state_d == S_DRAW_START);
      draw_game_q  <= (state_d == S_DRAW_GAME);
      draw_over_q  <= (state_d == S_DRAW_OVER);
      pix_q        <= pix_d;
      plot_q       <= plot_d;
    end
  end

  assign state      = state_q;
  assign draw_start = draw_start_q;
  assign draw_game  = draw_game_q;
  assign draw_over  = draw_over_q;
  assign vga_colour = pix_q.colour;
  assign vga_x      = pix_q.x;
  assign vga_y      = pix_q.y;
  assign vga_plot   = plot_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: directed screen walk plus random phase, checked
// cycle by cycle against a reference model through an expectation queue.
// Ports: none.
module tb_screen_sequencer;

  localparam int TB_TO = 100;
`ifdef SCREEN_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       start_n;
  logic       game_over;
  logic       done_start, done_game, done_over;
  logic [2:0] src0_colour, src1_colour, src2_colour;
  logic [7:0] src0_x, src1_x, src2_x;
  logic [6:0] src0_y, src1_y, src2_y;
  logic       src1_plot;
  logic       draw_start, draw_game, draw_over;
  logic [2:0] vga_colour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic       vga_plot;
  logic [2:0] state;
  logic       timeout_err;

  screen_sequencer #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .reset(reset), .start_n(start_n), .game_over(game_over),
    .done_start(done_start), .done_game(done_game), .done_over(done_over),
    .src0_colour(src0_colour), .src0_x(src0_x), .src0_y(src0_y),
    .src1_colour(src1_colour), .src1_x(src1_x), .src1_y(src1_y),
    .src2_colour(src2_colour), .src2_x(src2_x), .src2_y(src2_y),
    .src1_plot(src1_plot),
    .draw_start(draw_start), .draw_game(draw_game), .draw_over(draw_over),
    .vga_colour(vga_colour), .vga_x(vga_x), .vga_y(vga_y), .vga_plot(vga_plot),
    .state(state), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] draws;   // {start, game, over}
    logic       plot;
    logic [2:0] col;
    logic [7:0] x;
    logic [6:0] y;
    logic       err;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  // ---------------- reference model ----------------
  int       m_st;
  int       m_dwell;     // cycles the current state has already been held
  bit       m_err;
  bit       m_plot;
  bit [2:0] m_col;
  bit [7:0] m_x;
  bit [6:0] m_y;
  bit [2:0] m_draws;
  bit       h1, h2, h3;  // start_n as sampled 1, 2, 3 edges ago

  task automatic model_edge();
    int nst;
    bit press, is_draw, done_cur, timed, psel;
    if (!reset) begin
      m_st = 0; m_dwell = 0; m_err = 0; m_plot = 0;
      m_col = 0; m_x = 0; m_y = 0; m_draws = 3'b000;
      h1 = 1; h2 = 1; h3 = 1;
    end else begin
      // a press is seen two edges after the first low sample, once
      press = h3 && !h2;
      h3 = h2; h2 = h1; h1 = start_n;
      is_draw  = (m_st == 0) || (m_st == 2) || (m_st == 4);
      done_cur = (m_st == 0) ? done_start :
                 (m_st == 2) ? done_game  :
                 (m_st == 4) ? done_over  : 1'b0;
      timed = TO_EN && is_draw && !done_cur && (m_dwell == TB_TO - 1);
      nst = m_st;
      case (m_st)
        0: if (done_cur || timed) nst = 1;
        1: if (press)             nst = 2;
        2: if (done_cur || timed) nst = 3;
        3: if (game_over)         nst = 4;
        4: if (done_cur || timed) nst = 5;
        5: if (press)             nst = 0;
        default:                  nst = 0;
      endcase
      psel = 0;
      case (m_st)
        0: begin m_col = src0_colour; m_x = src0_x; m_y = src0_y; psel = 1; end
        2: begin m_col = src1_colour; m_x = src1_x; m_y = src1_y; psel = 1; end
        4: begin m_col = src2_colour; m_x = src2_x; m_y = src2_y; psel = 1; end
        3: begin m_col = src1_colour; m_x = src1_x; m_y = src1_y; psel = src1_plot; end
        default: ;
      endcase
      m_plot  = psel && (nst == m_st);
      m_err   = m_err | timed;
      m_dwell = (nst == m_st) ? m_dwell + 1 : 0;
      m_st    = nst;
      m_draws = {m_st == 0, m_st == 2, m_st == 4};
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic rand_pixels();
    src0_colour = 3'($urandom); src0_x = 8'($urandom); src0_y = 7'($urandom);
    src1_colour = 3'($urandom); src1_x = 8'($urandom); src1_y = 7'($urandom);
    src2_colour = 3'($urandom); src2_x = 8'($urandom); src2_y = 7'($urandom);
    src1_plot   = 1'($urandom);
  endtask

  task automatic step(input string tag);
    obs_t e;
    @(posedge clk);
    #1;
    model_edge();
    e.st = 3'(m_st); e.draws = m_draws; e.plot = m_plot;
    e.col = m_col; e.x = m_x; e.y = m_y; e.err = m_err;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    rand_pixels();
  endtask

  // ---------------- monitor ----------------
  obs_t  mon_e, mon_a;
  string mon_t;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      mon_a.st = state; mon_a.draws = {draw_start, draw_game, draw_over};
      mon_a.plot = vga_plot; mon_a.col = vga_colour; mon_a.x = vga_x;
      mon_a.y = vga_y; mon_a.err = timeout_err;
      total++;
      if (mon_a !== mon_e) begin
        bad++;
        $display("FAIL %s @%0t: got st=%0d draw=%b plot=%b col=%0d x=%0d y=%0d err=%b, want st=%0d draw=%b plot=%b col=%0d x=%0d y=%0d err=%b",
                 mon_t, $time, mon_a.st, mon_a.draws, mon_a.plot, mon_a.col, mon_a.x, mon_a.y, mon_a.err,
                 mon_e.st, mon_e.draws, mon_e.plot, mon_e.col, mon_e.x, mon_e.y, mon_e.err);
      end
    end
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 0; start_n = 1; game_over = 0;
    done_start = 0; done_game = 0; done_over = 0;
    rand_pixels();
    repeat (3) step("reset");
    reset = 1;

    // start screen drawn for 19200 cycles, foreign done flags ignored
    for (int i = 0; i < 19199; i++) begin
      done_game = ($urandom_range(0, 7) == 0);
      done_over = ($urandom_range(0, 7) == 0);
      step("draw_start");
    end
    done_game = 0; done_over = 0; done_start = 1;
    step("done_start");
    done_start = 0;
    repeat (3) step("wait_start");

    // key held 50 cycles: one press only; stray done_over in DRAW_GAME
    start_n = 0;
    for (int i = 0; i < 50; i++) begin
      done_over = (i >= 3) && (i < 9);
      done_game = (i == 10);
      step("hold_key");
    end
    done_over = 0; done_game = 0; start_n = 1;

    // play with a dropped key press
    for (int i = 0; i < 40; i++) begin
      if (i == 10) start_n = 0;
      if (i == 15) start_n = 1;
      step("play");
    end

    // game_over and press on the same edge
    start_n = 0; step("over_press");
    step("over_press");
    game_over = 1; step("over_press");
    game_over = 0; start_n = 1;

    for (int i = 0; i < 30; i++) begin
      done_start = ($urandom_range(0, 3) == 0);
      done_game  = ($urandom_range(0, 3) == 0);
      step("draw_over");
    end
    done_start = 0; done_game = 0; done_over = 1; step("done_over");
    done_over = 0;
    repeat (5) step("wait_over");
    start_n = 0; repeat (5) step("restart");
    start_n = 1; repeat (5) step("restart");

    // back to play, then a single-cycle reset
    done_start = 1; step("to_play");
    done_start = 0; step("to_play");
    start_n = 0; repeat (4) step("to_play");
    start_n = 1; done_game = 1; step("to_play");
    done_game = 0; repeat (10) step("to_play");
    reset = 0; step("reset_play");
    reset = 1; repeat (5) step("after_reset");

    // no done at all: watchdog boundary when enabled
    for (int i = 0; i < 150; i++) step("no_done");

    // random phase
    for (int i = 0; i < 3000; i++) begin
      done_start = ($urandom_range(0, 15) == 0);
      done_game  = ($urandom_range(0, 15) == 0);
      done_over  = ($urandom_range(0, 15) == 0);
      game_over  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) start_n = ~start_n;
      reset = ($urandom_range(0, 199) != 0);
      step("random");
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
